vga_sync_recv: RTL and testbench
================================

// Module: vga_sync_recv
// PURPOSE
//  Receive-side counterpart of the VGA timing generator. Samples incoming hsync/vsync
//  (active-high pulse, as our generator drives them) on pixel-enable strobes, checks
//  line/frame geometry against 640x480@60 timing and declares lock. Once locked,
//  recovers the pixel coordinate and data-enable. Used for loopback checking and capture.
// PARAMETERS
//  H_PULSE     96   hsync high width, px
//  H_BACK      144  first visible px index, counted from hsync rise
//  H_VIS_END   784  first non-visible px index after the visible area
//  H_TOTAL     800  px per line
//  V_PULSE     2    vsync high width, lines
//  V_BACK      35   first visible line index, counted from vsync rise
//  V_VIS_END   515  first non-visible line index after the visible area
//  V_TOTAL     525  lines per frame
//  LOCK_LINES  4    consecutive good lines needed to leave SEARCH (1..15)
// PORTS
//  clk           in   1   system clock
//  i_rst_n       in   1   asynchronous active-low reset
//  i_px_en       in   1   pixel strobe; all sampling/counting only on i_px_en=1 cycles
//  i_hsync       in   1   hsync, synchronous to clk, high = pulse
//  i_vsync       in   1   vsync, synchronous to clk, high = pulse
//  o_locked      out  1   state==LOCKED
//  o_de          out  1   visible pixel (only when locked)
//  o_x           out  10  visible column 0..639, 0 when o_de=0
//  o_y           out  10  visible row 0..479, 0 when o_de=0
//  o_frame_start out  1   1-clk pulse on vsync rise while locked
//  o_line_err    out  1   1-clk pulse on any geometry error in HLOCK/LOCKED
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=SEARCH, all counters/flags/outputs 0, hs_q=vs_q=0.
//  Sampling, per i_px_en=1 cycle: h_rise = i_hsync & ~hs_q; h_fall = ~i_hsync & hs_q; hs_q<=i_hsync.
//  hcnt (10b): h_rise -> 0; else +1, saturating at 1023. Checks always use pre-update hcnt.
//  Fall check: h_fall & hcnt!=H_PULSE-1 -> hw_bad<=1 (i.e. fall sample index must be H_PULSE).
//  Line check on h_rise: good = (hcnt==H_TOTAL-1) & ~hw_bad & a fall was seen; clear hw_bad/fall flag.
//  Vertical sampled only on h_rise: v_rise = i_vsync & ~vs_q; v_fall likewise; vs_q<=i_vsync.
//  vcnt (10b): v_rise -> 0; else on h_rise +1, saturating at 1023.
//  Frame check on v_rise: good = (vcnt==V_TOTAL-1) & vsync fall seen at line index V_PULSE.
//  FSM:
//   SEARCH: good-line counter +1 per good line, cleared by bad line; at LOCK_LINES -> HLOCK.
//   HLOCK : first v_rise arms frame measurement (v_seen<=1); next v_rise: good frame -> LOCKED,
//           bad -> SEARCH.
//   LOCKED: stays while every line and frame is good.
//   Bad line, bad frame, or hcnt reaching 1023 (hsync lost) in HLOCK/LOCKED -> SEARCH,
//   o_line_err=1 for that one clk. In SEARCH errors only clear the good-line counter, no o_line_err.
//  Outputs registered, updated on i_px_en cycles; reflect the sample taken that cycle (1-clk latency):
//   o_de = LOCKED & H_BACK<=hcnt'<H_VIS_END & V_BACK<=vcnt'<V_VIS_END (hcnt'/vcnt' = post-update).
//   o_x = hcnt'-H_BACK, o_y = vcnt'-V_BACK when o_de, else 0. Widths: 10b, no overflow by range.
//  o_frame_start: asserted for the clk after a v_rise sample while in LOCKED (incl. the
//   transition into LOCKED).
//  Outputs hold between strobes except o_frame_start/o_line_err, which are 1-clk pulses.
//  i_px_en=0 freezes all state. Leaving LOCKED clears o_de/o_x/o_y on the same update.
// TESTING
//  1 Assert i_rst_n=0 mid-stream -> all outputs 0 asynchronously, state SEARCH; release -> relock.
//  2 Ideal 640x480 stream, i_px_en every 4th clk -> o_locked after 4 lines + 2 vsync rises;
//    per locked frame 307200 o_de px, o_x 0..639, o_y 0..479, 1 o_frame_start.
//  3 Locked, inject one line of 799 px -> one o_line_err pulse, o_locked=0, relock next frame.
//  4 Locked, hsync pulse 95 px on one line -> o_line_err, SEARCH; 4 good lines -> HLOCK.
//  5 Locked, hold hsync low 1100 px -> o_line_err when hcnt hits 1023, o_locked=0, o_de=0.
//  6 Frame of 524 lines or vsync width 3 in HLOCK -> SEARCH, o_locked never asserted.

Source files
------------

// File: rtl/vga_sync_recv.sv
// vga_sync_recv: locks onto an incoming hsync/vsync stream of known geometry and,
// once locked, recovers the visible pixel coordinate and data-enable.
module vga_sync_recv #(
  parameter int unsigned H_PULSE    = 96,
  parameter int unsigned H_BACK     = 144,
  parameter int unsigned H_VIS_END  = 784,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_PULSE    = 2,
  parameter int unsigned V_BACK     = 35,
  parameter int unsigned V_VIS_END  = 515,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_px_en,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic       o_locked,
  output logic       o_de,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_line_err
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_HLOCK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [GW-1:0]   r_good_cnt;
  logic [GW-1:0]   w_good_cnt_nx;
  logic            r_v_seen;
  logic            w_v_seen_nx;
  logic            w_frame_start;
  logic            w_line_err;

  logic            r_hs_q;
  logic            r_vs_q;
  logic [CW-1:0]   r_hcnt;
  logic [CW-1:0]   r_vcnt;
  logic            r_hw_bad;
  logic            r_hfall_seen;
  logic            r_vfall_ok;

  logic            r_locked;
  logic            r_de;
  logic [CW-1:0]   r_x;
  logic [CW-1:0]   r_y;
  logic            r_frame_start;
  logic            r_line_err;

  logic            w_h_rise;
  logic            w_h_fall;
  logic            w_v_rise;
  logic            w_v_fall;
  logic            w_line_bad;
  logic            w_frame_bad;
  logic            w_h_lost;
  logic [CW-1:0]   w_hcnt_nx;
  logic [CW-1:0]   w_vcnt_nx;
  logic            w_de;

  // Edge detection and line/frame verdicts, all against pre-update counters
  assign w_h_rise    = i_px_en & i_hsync & ~r_hs_q;
  assign w_h_fall    = i_px_en & ~i_hsync & r_hs_q;
  assign w_v_rise    = w_h_rise & i_vsync & ~r_vs_q;
  assign w_v_fall    = w_h_rise & ~i_vsync & r_vs_q;
  assign w_line_bad  = w_h_rise &
                       ~((r_hcnt == CW'(H_TOTAL - 1)) & r_hfall_seen & ~r_hw_bad);
  assign w_frame_bad = w_v_rise & ~((r_vcnt == CW'(V_TOTAL - 1)) & r_vfall_ok);
  assign w_h_lost    = i_px_en & ~w_h_rise & (r_hcnt == (CNT_MAX - CW'(1)));

  // Post-update counter values; both saturate instead of wrapping
  assign w_hcnt_nx = w_h_rise ? '0 :
                     (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CW'(1);
  assign w_vcnt_nx = w_v_rise ? '0 :
                     (w_h_rise && (r_vcnt != CNT_MAX)) ? r_vcnt + CW'(1) : r_vcnt;

  assign w_de = (w_state_nx == S_LOCKED) &
                (w_hcnt_nx >= CW'(H_BACK)) & (w_hcnt_nx < CW'(H_VIS_END)) &
                (w_vcnt_nx >= CW'(V_BACK)) & (w_vcnt_nx < CW'(V_VIS_END));

  // Lock state register with good-line counter and frame-arming flag
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= '0;
      r_v_seen   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_good_cnt_nx;
      r_v_seen   <= w_v_seen_nx;
    end
  end

  // Lock next-state: SEARCH counts good lines, HLOCK measures one frame, LOCKED checks all
  always_comb begin
    w_state_nx    = r_state;
    w_good_cnt_nx = r_good_cnt;
    w_v_seen_nx   = r_v_seen;
    w_frame_start = 1'b0;
    w_line_err    = 1'b0;
    if (i_px_en) begin
      unique case (r_state)
        S_SEARCH: begin
          w_v_seen_nx = 1'b0;
          if (w_line_bad || w_h_lost || w_frame_bad) begin
            w_good_cnt_nx = '0;
          end else if (w_h_rise) begin
            if (r_good_cnt == GW'(LOCK_LINES - 1)) begin
              w_good_cnt_nx = '0;
              w_state_nx    = S_HLOCK;
            end else begin
              w_good_cnt_nx = r_good_cnt + GW'(1);
            end
          end
        end
        S_HLOCK: begin
          if (w_line_bad || w_h_lost || (w_frame_bad && r_v_seen)) begin
            w_state_nx  = S_SEARCH;
            w_v_seen_nx = 1'b0;
            w_line_err  = 1'b1;
          end else if (w_v_rise) begin
            if (r_v_seen) begin
              w_state_nx    = S_LOCKED;
              w_frame_start = 1'b1;
            end else begin
              w_v_seen_nx = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (w_line_bad || w_h_lost || w_frame_bad) begin
            w_state_nx  = S_SEARCH;
            w_v_seen_nx = 1'b0;
            w_line_err  = 1'b1;
          end else if (w_v_rise) begin
            w_frame_start = 1'b1;
          end
        end
        default: begin
          w_state_nx = S_SEARCH;
        end
      endcase
    end
  end

  // Sampling, counters, pulse-width flags and registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_q        <= 1'b0;
      r_vs_q        <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hw_bad      <= 1'b0;
      r_hfall_seen  <= 1'b0;
      r_vfall_ok    <= 1'b0;
      r_locked      <= 1'b0;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start;
      r_line_err    <= w_line_err;
      if (i_px_en) begin
        r_hs_q <= i_hsync;
        r_hcnt <= w_hcnt_nx;
        r_vcnt <= w_vcnt_nx;
        if (w_h_rise) begin
          r_vs_q       <= i_vsync;
          r_hw_bad     <= 1'b0;
          r_hfall_seen <= 1'b0;
        end else if (w_h_fall) begin
          r_hfall_seen <= 1'b1;
          if (r_hcnt != CW'(H_PULSE - 1)) r_hw_bad <= 1'b1;
        end
        if (w_v_rise) begin
          r_vfall_ok <= 1'b0;
        end else if (w_v_fall) begin
          r_vfall_ok <= (r_vcnt == CW'(V_PULSE - 1));
        end
        r_locked <= (w_state_nx == S_LOCKED);
        r_de     <= w_de;
        r_x      <= w_de ? (w_hcnt_nx - CW'(H_BACK)) : '0;
        r_y      <= w_de ? (w_vcnt_nx - CW'(V_BACK)) : '0;
      end
    end
  end

  assign o_locked      = r_locked;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;
  assign o_line_err    = r_line_err;

endmodule

// File: tb/tb_vga_sync_recv.sv
// tb_vga_sync_recv: table of stream segments with expected event counts, hand-written
// reset sequence, and a randomized stream, all shadowed by a cycle-level reference model.
module tb_vga_sync_recv;

  // Reduced geometry so whole frames fit in a short run
  localparam int H_PULSE    = 4;
  localparam int H_BACK     = 6;
  localparam int H_VIS_END  = 14;
  localparam int H_TOTAL    = 16;
  localparam int V_PULSE    = 2;
  localparam int V_BACK     = 3;
  localparam int V_VIS_END  = 7;
  localparam int V_TOTAL    = 9;
  localparam int LOCK_LINES = 4;
  localparam int VIS_W      = H_VIS_END - H_BACK;
  localparam int DE_FRAME   = VIS_W * (V_VIS_END - V_BACK);

  localparam int K_NONE = 0, K_SHORT_LINE = 1, K_NARROW = 2, K_LOST = 3,
                 K_SHORT_FRAME = 4, K_WIDE_V = 5;
  localparam int M_SEARCH = 0, M_HLOCK = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_px_en;
  logic       i_hsync;
  logic       i_vsync;
  logic       o_locked;
  logic       o_de;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_frame_start;
  logic       o_line_err;

  vga_sync_recv #(
    .H_PULSE(H_PULSE), .H_BACK(H_BACK), .H_VIS_END(H_VIS_END), .H_TOTAL(H_TOTAL),
    .V_PULSE(V_PULSE), .V_BACK(V_BACK), .V_VIS_END(V_VIS_END), .V_TOTAL(V_TOTAL),
    .LOCK_LINES(LOCK_LINES)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_px_en(i_px_en), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .o_locked(o_locked), .o_de(o_de), .o_x(o_x), .o_y(o_y),
    .o_frame_start(o_frame_start), .o_line_err(o_line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    rst;
    int    nfr;
    int    sp_fr;
    int    kind;
    int    e_de;
    int    e_fs;
    int    e_err;
    int    e_lock;
  } seg_t;

  seg_t  segs [10];
  int    n_checks = 0;
  int    n_errors = 0;
  int    g_gap    = 3;
  int    seg_bad, cnt_de, cnt_fs, cnt_err;
  string first_diff;

  // Reference model: distances since the last hsync/vsync rise, in pixels and lines
  int   m_px, m_hfall, m_ln, m_vfall, m_good, m_mode;
  bit   m_armed, m_ph, m_pv;
  logic e_locked, e_de, e_fs, e_err;
  logic [9:0] e_x, e_y;

  function automatic void model_reset();
    m_px = 0; m_hfall = -1; m_ln = 0; m_vfall = -1; m_good = 0;
    m_mode = M_SEARCH; m_armed = 1'b0; m_ph = 1'b0; m_pv = 1'b0;
    e_locked = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_err = 1'b0; e_x = '0; e_y = '0;
  endfunction

  function automatic void model_step(input logic h, input logic v);
    bit rise, fall, vr, vf, line_ok, frame_ok, lost, bad;
    int hx, vy;
    rise     = h && !m_ph;
    fall     = !h && m_ph;
    vr       = rise && v && !m_pv;
    vf       = rise && !v && m_pv;
    line_ok  = (m_px + 1 == H_TOTAL) && (m_hfall == H_PULSE);
    frame_ok = (m_ln + 1 == V_TOTAL) && (m_vfall == V_PULSE);
    lost     = !rise && (m_px + 1 == 1023);
    bad      = (rise && !line_ok) || lost || (vr && !frame_ok);
    e_fs = 1'b0;
    e_err = 1'b0;
    if (m_mode == M_SEARCH) begin
      if (bad) m_good = 0;
      else if (rise) begin
        m_good++;
        if (m_good == LOCK_LINES) begin
          m_mode = M_HLOCK; m_good = 0; m_armed = 1'b0;
        end
      end
    end else if (m_mode == M_HLOCK) begin
      if ((rise && !line_ok) || lost || (vr && m_armed && !frame_ok)) begin
        m_mode = M_SEARCH; e_err = 1'b1;
      end else if (vr) begin
        if (m_armed) begin m_mode = M_LOCKED; e_fs = 1'b1; end
        else m_armed = 1'b1;
      end
    end else begin
      if (bad) begin m_mode = M_SEARCH; e_err = 1'b1; end
      else if (vr) e_fs = 1'b1;
    end
    if (rise) begin m_px = 0; m_hfall = -1; end
    else begin m_px++; if (fall) m_hfall = m_px; end
    if (vr) begin m_ln = 0; m_vfall = -1; end
    else if (rise) begin m_ln++; if (vf) m_vfall = m_ln; end
    if (rise) m_pv = v;
    m_ph = h;
    hx = (m_px > 1023) ? 1023 : m_px;
    vy = (m_ln > 1023) ? 1023 : m_ln;
    e_locked = (m_mode == M_LOCKED);
    e_de = e_locked && hx >= H_BACK && hx < H_VIS_END && vy >= V_BACK && vy < V_VIS_END;
    e_x = e_de ? 10'(hx - H_BACK) : 10'd0;
    e_y = e_de ? 10'(vy - V_BACK) : 10'd0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic seg_begin();
    seg_bad = 0; cnt_de = 0; cnt_fs = 0; cnt_err = 0; first_diff = "";
  endtask

  task automatic seg_model_chk(input string name);
    chk({"model_", name}, seg_bad, 0);
    if (seg_bad != 0) $display("  first divergence in %s: %s", name, first_diff);
  endtask

  // One clock: drive at negedge, compare every output against the model 1ns after posedge
  task automatic tick(input logic en, input logic h, input logic v);
    logic [23:0] act, exp;
    i_px_en = en; i_hsync = h; i_vsync = v;
    @(posedge clk);
    #1;
    if (en) model_step(h, v);
    else begin e_fs = 1'b0; e_err = 1'b0; end
    act = {o_locked, o_de, o_x, o_y, o_frame_start, o_line_err};
    exp = {e_locked, e_de, e_x, e_y, e_fs, e_err};
    if (act !== exp) begin
      if (seg_bad == 0)
        first_diff = $sformatf("t=%0t got %h want %h (lock,de,x,y,fs,err)", $time, act, exp);
      seg_bad++;
    end
    if (en && o_de) cnt_de++;
    if (o_frame_start) cnt_fs++;
    if (o_line_err) cnt_err++;
    @(negedge clk);
  endtask

  task automatic strobe(input logic h, input logic v);
    int g;
    g = (g_gap < 0) ? int'($urandom_range(0, 3)) : g_gap;
    for (int i = 0; i < g; i++) tick(1'b0, h, v);
    tick(1'b1, h, v);
  endtask

  task automatic send_line(input int len, input int hpw, input logic vs);
    for (int p = 0; p < len; p++) strobe(logic'(p < hpw), vs);
  endtask

  task automatic send_frame(input int nl, input int vpw, input int bl,
                            input int blen, input int bhpw);
    for (int l = 0; l < nl; l++)
      send_line((l == bl) ? blen : H_TOTAL, (l == bl) ? bhpw : H_PULSE, logic'(l < vpw));
  endtask

  task automatic apply_reset(input string name);
    i_rst_n = 1'b0; i_px_en = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk({"reset_outs_", name}, int'({o_locked, o_de, o_x, o_y, o_frame_start, o_line_err}), 0);
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_seg(input seg_t s);
    int nl, vpw, bl, blen, bhpw;
    if (s.rst) apply_reset(s.name);
    seg_begin();
    if (s.kind == K_LOST) begin
      send_line(1100, 0, 1'b0);
    end else begin
      for (int f = 0; f < s.nfr; f++) begin
        nl   = (f == s.sp_fr && s.kind == K_SHORT_FRAME) ? V_TOTAL - 1 : V_TOTAL;
        vpw  = (f == s.sp_fr && s.kind == K_WIDE_V) ? V_PULSE + 1 : V_PULSE;
        bl   = (f == s.sp_fr && (s.kind == K_SHORT_LINE || s.kind == K_NARROW)) ? 5 : -1;
        blen = (s.kind == K_SHORT_LINE) ? H_TOTAL - 1 : H_TOTAL;
        bhpw = (s.kind == K_NARROW) ? H_PULSE - 1 : H_PULSE;
        send_frame(nl, vpw, bl, blen, bhpw);
      end
    end
    seg_model_chk(s.name);
    chk({"de_count_", s.name}, cnt_de, s.e_de);
    chk({"frame_start_", s.name}, cnt_fs, s.e_fs);
    chk({"line_err_", s.name}, cnt_err, s.e_err);
    chk({"locked_end_", s.name}, int'(o_locked), s.e_lock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, vpw, len, hpw;
    segs[0] = '{"lock_from_reset", 1'b1, 3, -1, K_NONE,        DE_FRAME,     1, 0, 1};
    segs[1] = '{"ideal_locked",    1'b0, 2, -1, K_NONE,        2 * DE_FRAME, 2, 0, 1};
    segs[2] = '{"short_line",      1'b0, 1,  0, K_SHORT_LINE,  3 * VIS_W,    1, 1, 0};
    segs[3] = '{"relock_a",        1'b0, 3, -1, K_NONE,        DE_FRAME,     1, 0, 1};
    segs[4] = '{"narrow_hsync",    1'b0, 1,  0, K_NARROW,      3 * VIS_W,    1, 1, 0};
    segs[5] = '{"relock_b",        1'b0, 3, -1, K_NONE,        DE_FRAME,     1, 0, 1};
    segs[6] = '{"hsync_lost",      1'b0, 0, -1, K_LOST,        0,            0, 1, 0};
    segs[7] = '{"relock_c",        1'b0, 3, -1, K_NONE,        DE_FRAME,     1, 0, 1};
    segs[8] = '{"short_frame",     1'b1, 2,  1, K_SHORT_FRAME, 0,            0, 0, 0};
    segs[9] = '{"wide_vsync",      1'b0, 3,  1, K_WIDE_V,      0,            0, 2, 0};

    i_rst_n = 1'b0; i_px_en = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    model_reset();
    g_gap = 3;
    for (int i = 0; i < 10; i++) run_seg(segs[i]);

    // Asynchronous reset in the middle of a visible line, then relock
    apply_reset("pre_async");
    seg_begin();
    for (int f = 0; f < 3; f++) send_frame(V_TOTAL, V_PULSE, -1, H_TOTAL, H_PULSE);
    for (int l = 0; l < 4; l++) send_line(H_TOTAL, H_PULSE, logic'(l < V_PULSE));
    for (int p = 0; p < 10; p++) strobe(logic'(p < H_PULSE), 1'b0);
    seg_model_chk("pre_async");
    chk("visible_de", int'(o_de), 1);
    chk("visible_x", int'(o_x), 3);
    chk("visible_y", int'(o_y), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outs", int'({o_locked, o_de, o_x, o_y, o_frame_start, o_line_err}), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    seg_begin();
    for (int f = 0; f < 3; f++) send_frame(V_TOTAL, V_PULSE, -1, H_TOTAL, H_PULSE);
    seg_model_chk("post_async");
    chk("post_async_de", cnt_de, DE_FRAME);
    chk("post_async_fs", cnt_fs, 1);
    chk("post_async_locked", int'(o_locked), 1);

    // Randomized stream with occasional geometry faults and irregular strobes
    g_gap = -1;
    seg_begin();
    for (int f = 0; f < 16; f++) begin
      nl  = ($urandom_range(0, 9) == 0) ?
            (($urandom_range(0, 1) == 0) ? V_TOTAL - 1 : V_TOTAL + 1) : V_TOTAL;
      vpw = ($urandom_range(0, 9) == 0) ? V_PULSE + 1 : V_PULSE;
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 39) == 0) ?
              (($urandom_range(0, 1) == 0) ? H_TOTAL - 1 : H_TOTAL + 1) : H_TOTAL;
        hpw = ($urandom_range(0, 39) == 0) ?
              (($urandom_range(0, 1) == 0) ? H_PULSE - 1 : H_PULSE + 1) : H_PULSE;
        send_line(len, hpw, logic'(l < vpw));
      end
    end
    seg_model_chk("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
